// File: rtl/ram_access_arbiter_pkg.sv
// Shared definitions for the RAM access arbiter: RAM command opcodes, FSM states
// and a helper that packs a RAM command word.
package ram_arb_pkg;

  localparam int unsigned CMD_W = 10;

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WDATA = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;
  localparam logic [1:0] CMD_RCMD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_RCMD,
    ST_RD_WAIT,
    ST_RESP
  } state_e;

  function automatic logic [CMD_W-1:0] make_cmd(input logic [1:0] op, input logic [7:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester-side and RAM-side bus of the RAM access arbiter; the arbiter uses
// the slave modport, requesters/RAM (or a bench) the master modport.
interface ram_access_arbiter_if #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_SIZE = 8
);
  import ram_arb_pkg::*;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_write;
  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr;
  logic [NUM_REQ*8-1:0]         req_wdata;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [NUM_REQ-1:0]           rsp_ready;
  logic [7:0]                   rsp_rdata;
  logic                         rsp_err;
  logic [CMD_W-1:0]             ram_din;
  logic                         ram_rx_valid;
  logic [7:0]                   ram_dout;
  logic                         ram_tx_valid;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, ram_dout, ram_tx_valid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, ram_dout, ram_tx_valid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid
  );

endinterface

// File: rtl/ram_access_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request scanning upward from
// the slot after ptr_i, wrapping at NUM_REQ-1.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one single-port RAM command port among NUM_REQ
// requesters. Optional read watchdog enabled by defining RD_TIMEOUT_EN.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_SIZE      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                clk,
  input logic                rst_n,
  ram_access_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (ADDR_SIZE != 8) begin : g_bad_addr
    $error("ram_access_arbiter: ADDR_SIZE must be 8");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("ram_access_arbiter: TIMEOUT_CYCLES must be non-zero");
  end

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic                 wr_q, wr_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [7:0]           rdata_q, rdata_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_any;

`ifdef RD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef RD_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef RD_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    wr_d             = wr_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    rdata_d          = rdata_q;
    bus.req_ready    = '0;
    bus.rsp_valid    = '0;
    bus.rsp_rdata    = '0;
    bus.rsp_err      = 1'b0;
    bus.ram_din      = '0;
    bus.ram_rx_valid = 1'b0;
`ifdef RD_TIMEOUT_EN
    cnt_d            = cnt_q;
    err_d            = err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // A grant is suppressed while reset is held so every output reads 0.
        if (gnt_any && rst_n) begin
          bus.req_ready = gnt;
          ptr_d         = gnt_idx;
          wr_d          = bus.req_write[gnt_idx];
          addr_d        = bus.req_addr[gnt_idx*ADDR_SIZE +: ADDR_SIZE];
          wdata_d       = bus.req_wdata[gnt_idx*8 +: 8];
          rdata_d       = '0;
`ifdef RD_TIMEOUT_EN
          err_d         = 1'b0;
`endif
          state_d       = ST_ADDR;
        end
      end
      ST_ADDR: begin
        bus.ram_din      = make_cmd(wr_q ? CMD_WADDR : CMD_RADDR, addr_q);
        bus.ram_rx_valid = 1'b1;
        state_d          = wr_q ? ST_WDATA : ST_RCMD;
      end
      ST_WDATA: begin
        bus.ram_din      = make_cmd(CMD_WDATA, wdata_q);
        bus.ram_rx_valid = 1'b1;
        state_d          = ST_RESP;
      end
      ST_RCMD: begin
        bus.ram_din      = make_cmd(CMD_RCMD, 8'h00);
        bus.ram_rx_valid = 1'b1;
`ifdef RD_TIMEOUT_EN
        cnt_d            = '0;
`endif
        state_d          = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // Data arriving on the expiry cycle takes priority over the timeout.
        if (bus.ram_tx_valid) begin
          rdata_d = bus.ram_dout;
          state_d = ST_RESP;
        end
`ifdef RD_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = 8'hFF;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        bus.rsp_valid[ptr_q] = 1'b1;
        bus.rsp_rdata        = rdata_q;
`ifdef RD_TIMEOUT_EN
        bus.rsp_err          = err_q;
`endif
        if (bus.rsp_ready[ptr_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
